// File: rtl/spi_reg_bridge_pkg.sv
// Shared constants and FSM state type for the SPI-to-register-file bridge.
package spi_bridge_pkg;

    localparam int unsigned HDR_BITS = 8;
    localparam int unsigned RW_BIT   = 7;
    localparam int unsigned ADDR_MSB = 2;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-file access bus between the SPI bridge (master) and the register file (slave).
interface spi_reg_bridge_if #(
    parameter int unsigned DATA_BITS = 16
);
    logic                                wr_en;
    logic [spi_bridge_pkg::ADDR_W-1:0]   wr_addr;
    logic [DATA_BITS-1:0]                wr_data;
    logic [spi_bridge_pkg::ADDR_W-1:0]   rd_addr;
    logic [DATA_BITS-1:0]                rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/spi_reg_bridge_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that decodes frames into register-file writes/reads, oversampled on clk.
// Read-back over MISO is built only when SPI_READBACK_EN is defined.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned NUM_REGS  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     busy,
    output logic                     frame_err,
    spi_reg_bridge_if.master         reg_bus
);

    localparam int unsigned FRAME_BITS = HDR_BITS + DATA_BITS;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sig;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    // Resets low so a cs_n held low across reset never looks like a new frame start.
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
    );

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   rx_q, rx_d, rx_next;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   addr_ok;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
`ifdef SPI_READBACK_EN
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   load_q, load_d;
    logic [DATA_BITS-1:0]   tx_q, tx_d;
    logic                   miso_q, miso_d;
`endif

    assign rx_next = {rx_q[DATA_BITS-2:0], mosi_lvl};
    assign addr_ok = 32'(addr_q) < NUM_REGS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_READBACK_EN
            rd_addr_q   <= '0;
            load_q      <= 1'b0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef SPI_READBACK_EN
            rd_addr_q   <= rd_addr_d;
            load_q      <= load_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
`endif
        end
    end

    // Frame sequencing, write decode and MISO shifting.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
`ifdef SPI_READBACK_EN
        rd_addr_d   = rd_addr_q;
        load_d      = 1'b0;
        tx_d        = tx_q;
        miso_d      = miso_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                rx_d  = '0;
                if (cs_fall) state_d = HDR;
            end
            HDR: begin
                if (cs_rise) begin
                    // A select pulse with no sclk activity is not a frame.
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    rx_d        = '0;
                end else if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
                        state_d = DATA;
                        rw_d    = rx_next[RW_BIT];
                        addr_d  = rx_next[ADDR_MSB:ADDR_LSB];
`ifdef SPI_READBACK_EN
                        if (!rx_next[RW_BIT]) begin
                            rd_addr_d = rx_next[ADDR_MSB:ADDR_LSB];
                            load_d    = 1'b1;
                        end
`endif
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    rx_d        = '0;
`ifdef SPI_READBACK_EN
                    tx_d        = '0;
                    miso_d      = 1'b0;
`endif
                end else begin
`ifdef SPI_READBACK_EN
                    // The fall right after the header must not shift: MSB has to stay up for bit 9.
                    if (load_q) begin
                        tx_d        = addr_ok ? reg_bus.rd_data : '0;
                        frame_err_d = !addr_ok;
                        miso_d      = tx_d[DATA_BITS-1];
                    end else if (sclk_fall && !rw_q && (cnt_q > CNT_W'(HDR_BITS))) begin
                        tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
                        miso_d = tx_q[DATA_BITS-2];
                    end
`endif
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_d = DONE;
`ifdef SPI_READBACK_EN
                            tx_d    = '0;
                            miso_d  = 1'b0;
`endif
                            if (rw_q) begin
                                if (addr_ok) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = addr_q;
                                    wr_data_d = rx_next;
                                end else begin
                                    frame_err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign reg_bus.wr_en   = wr_en_q;
    assign reg_bus.wr_addr = wr_addr_q;
    assign reg_bus.wr_data = wr_data_q;
    assign busy            = busy_q;
    assign frame_err       = frame_err_q;

`ifdef SPI_READBACK_EN
    assign reg_bus.rd_addr = rd_addr_q;
    assign miso            = miso_q;
    assign unused_sig      = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};
`else
    assign reg_bus.rd_addr = '0;
    assign miso            = 1'b0;
    assign unused_sig      = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall, sclk_fall, reg_bus.rd_data};
`endif

endmodule
